uart_tx_cfg: RTL and testbench

Parametrised, configurable-frame UART transmitter with an internal transmit FIFO. It serves as the next-generation console/debug TX path for the RISC-V SoC peripheral bus. Firmware pushes bytes into the FIFO, and the block serialises them on `o_txd` using a runtime-selected data width, parity mode, stop-bit count and bit period. Frame configuration is latched per frame.

---
 rtl/uart_tx_cfg.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with an 8-bit transmit FIFO. Each frame's
// width, parity mode, stop-bit count and bit period are latched when the
// frame starts, so the config inputs may change freely while a frame is
// on the line.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line idle (txd=1); pop and start a frame when FIFO non-empty
// S_START  | start bit (txd=0) for one bit time
// S_DATA   | N data bits, LSB first, one bit time each
// S_PARITY | single parity bit (odd / even / mark)
// S_STOP   | 1 or 2 stop bits; chain straight into the next start if queued
`timescale 1ns/1ps
module uart_tx_cfg #(
   parameter int FIFO_AW  = 3,
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [PERIOD_W-1:0] i_period,
   input  logic [1:0]          i_data_bits,
   input  logic [1:0]          i_parity,
   input  logic                i_stop2,
   input  logic [7:0]          i_din,
   input  logic                i_valid,
   output logic                fifo_empty,
   output logic                fifo_full,
   output logic [FIFO_AW:0]    o_level,
   output logic                o_busy,
   output logic                o_ovf,
   output logic                o_txd
);

   localparam int               FIFO_DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_L    = (FIFO_AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q;
   logic [FIFO_AW-1:0] rd_ptr_q;
   logic [FIFO_AW:0]   level_q;
   logic [FIFO_AW:0]   level_d;
   logic               ovf_q;

   // Transmit engine
   state_t             state_q;
   logic               txd_q;
   logic               busy_q;
   logic [7:0]         shift_q;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] timer_q;
   logic [1:0]         nbits_q;
   logic [1:0]         parity_q;
   logic               stop2_q;
   logic               stop_more_q;
   logic               par_bit_q;
   logic [2:0]         bit_idx_q;

   logic               push;
   logic               pop;
   logic               tick;
   logic               frame_end;
   logic               last_data;
   logic [7:0]         head;
   logic [7:0]         mask_d;
   logic               par_even_d;
   logic               par_bit_d;

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == DEPTH_L);
   assign o_level    = level_q;
   assign o_ovf      = ovf_q;
   assign o_busy     = busy_q;
   assign o_txd      = txd_q;

   assign head      = mem_q[rd_ptr_q];
   assign tick      = (timer_q == '0);
   // Final stop-bit clock: the only point besides IDLE where a pop may happen,
   // which is what gives back-to-back frames with no idle gap.
   assign frame_end = (state_q == S_STOP) && tick && !stop_more_q;
   // Index of the last data bit is N-1 = 4 + nbits.
   assign last_data = (bit_idx_q == {1'b1, nbits_q});
   assign push      = i_valid && !fifo_full;
   assign pop       = !fifo_empty && ((state_q == S_IDLE) || frame_end);

   // Parity of the head entry, restricted to the width being latched for it.
   always_comb begin
      mask_d     = 8'hFF >> (2'd3 - i_data_bits);
      par_even_d = ^(head & mask_d);
      par_bit_d  = 1'b1;
      case (i_parity)
         2'b01:   par_bit_d = ~par_even_d;
         2'b10:   par_bit_d = par_even_d;
         default: par_bit_d = 1'b1;
      endcase
   end

   // Occupancy after this edge's push and/or pop.
   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
         2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   // FIFO data array; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (reset_n && push) begin
         mem_q[wr_ptr_q] <= i_din;
      end
   end

   // FIFO pointers, level and overflow pulse.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
         level_q <= level_d;
         ovf_q   <= i_valid && fifo_full;
      end
   end

   // Frame sequencer with bit timer and registered serial output.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         txd_q       <= 1'b1;
         busy_q      <= 1'b0;
         shift_q     <= '0;
         period_q    <= '0;
         timer_q     <= '0;
         nbits_q     <= '0;
         parity_q    <= '0;
         stop2_q     <= 1'b0;
         stop_more_q <= 1'b0;
         par_bit_q   <= 1'b0;
         bit_idx_q   <= '0;
      end else if (pop) begin
         state_q     <= S_START;
         txd_q       <= 1'b0;
         busy_q      <= 1'b1;
         shift_q     <= head;
         period_q    <= i_period;
         timer_q     <= i_period;
         nbits_q     <= i_data_bits;
         parity_q    <= i_parity;
         stop2_q     <= i_stop2;
         stop_more_q <= 1'b0;
         par_bit_q   <= par_bit_d;
         bit_idx_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               txd_q  <= 1'b1;
               busy_q <= 1'b0;
            end
            S_START: begin
               if (tick) begin
                  state_q <= S_DATA;
                  txd_q   <= shift_q[0];
                  timer_q <= period_q;
               end else begin
                  timer_q <= timer_q - PERIOD_W'(1);
               end
            end
            S_DATA: begin
               if (tick) begin
                  timer_q <= period_q;
                  if (last_data) begin
                     if (parity_q != 2'b00) begin
                        state_q <= S_PARITY;
                        txd_q   <= par_bit_q;
                     end else begin
                        state_q     <= S_STOP;
                        txd_q       <= 1'b1;
                        stop_more_q <= stop2_q;
                     end
                  end else begin
                     shift_q   <= shift_q >> 1;
                     txd_q     <= shift_q[1];
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  timer_q <= timer_q - PERIOD_W'(1);
               end
            end
            S_PARITY: begin
               if (tick) begin
                  state_q     <= S_STOP;
                  txd_q       <= 1'b1;
                  stop_more_q <= stop2_q;
                  timer_q     <= period_q;
               end else begin
                  timer_q <= timer_q - PERIOD_W'(1);
               end
            end
            S_STOP: begin
               if (tick) begin
                  timer_q <= period_q;
                  if (stop_more_q) begin
                     stop_more_q <= 1'b0;
                  end else begin
                     state_q <= S_IDLE;
                     txd_q   <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  timer_q <= timer_q - PERIOD_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               txd_q   <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: directed scenarios plus random traffic, every cycle
// compared against a frame-level model (byte queue + expected line waveform).
`timescale 1ns/1ps
module tb_uart_tx_cfg;

   localparam int FIFO_AW  = 3;
   localparam int PERIOD_W = 16;
   localparam int DEPTH    = 1 << FIFO_AW;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [PERIOD_W-1:0] i_period;
   logic [1:0]          i_data_bits;
   logic [1:0]          i_parity;
   logic                i_stop2;
   logic [7:0]          i_din;
   logic                i_valid;
   logic                fifo_empty;
   logic                fifo_full;
   logic [FIFO_AW:0]    o_level;
   logic                o_busy;
   logic                o_ovf;
   logic                o_txd;

   always #5 clk = ~clk;

   uart_tx_cfg #(.FIFO_AW(FIFO_AW), .PERIOD_W(PERIOD_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_period    (i_period),
      .i_data_bits (i_data_bits),
      .i_parity    (i_parity),
      .i_stop2     (i_stop2),
      .i_din       (i_din),
      .i_valid     (i_valid),
      .fifo_empty  (fifo_empty),
      .fifo_full   (fifo_full),
      .o_level     (o_level),
      .o_busy      (o_busy),
      .o_ovf       (o_ovf),
      .o_txd       (o_txd)
   );

   int checks   = 0;
   int failures = 0;

   // Model: queued bytes and the per-clock line level still to be driven
   // for the frame in flight (front = value expected right now).
   logic [7:0] mq[$];
   bit         wq[$];
   bit         exp_ovf;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expand one byte into its frame, each bit held for period+1 clocks.
   task automatic build_frame(input logic [7:0] b);
      int n;
      int ones;
      bit bits[$];
      n    = 5 + int'(i_data_bits);
      ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         bits.push_back(b[i]);
         ones += int'(b[i]);
      end
      case (i_parity)
         2'b01: bits.push_back((ones % 2) == 0);
         2'b10: bits.push_back((ones % 2) == 1);
         2'b11: bits.push_back(1'b1);
         default: ;
      endcase
      bits.push_back(1'b1);
      if (i_stop2) bits.push_back(1'b1);
      foreach (bits[j]) begin
         repeat (int'(i_period) + 1) wq.push_back(bits[j]);
      end
   endtask

   task automatic model_edge();
      int pre;
      if (!reset_n) begin
         mq.delete();
         wq.delete();
         exp_ovf = 1'b0;
      end else begin
         pre = mq.size();
         if (wq.size() > 0) void'(wq.pop_front());
         if (wq.size() == 0 && pre > 0) build_frame(mq.pop_front());
         exp_ovf = i_valid && (pre == DEPTH);
         if (i_valid && pre < DEPTH) mq.push_back(i_din);
      end
   endtask

   task automatic compare();
      check_eq("txd",   o_txd,      (wq.size() > 0) ? wq[0] : 1'b1);
      check_eq("busy",  o_busy,     wq.size() > 0);
      check_eq("level", o_level,    mq.size());
      check_eq("empty", fifo_empty, mq.size() == 0);
      check_eq("full",  fifo_full,  mq.size() == DEPTH);
      check_eq("ovf",   o_ovf,      exp_ovf);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic set_cfg(input int per, input logic [1:0] db, input logic [1:0] par, input logic s2);
      i_period    = PERIOD_W'(per);
      i_data_bits = db;
      i_parity    = par;
      i_stop2     = s2;
   endtask

   task automatic push_byte(input logic [7:0] b);
      i_valid = 1'b1;
      i_din   = b;
      step();
      i_valid = 1'b0;
   endtask

   task automatic drain(input string tag, input int limit);
      int n;
      n = 0;
      i_valid = 1'b0;
      while ((wq.size() > 0 || mq.size() > 0) && n < limit) begin
         step();
         n++;
      end
      check_eq({tag, "_bound"}, n < limit, 1'b1);
      step();
      check_eq({tag, "_idle"}, o_busy, 1'b0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ovf_seen;
      reset_n = 1'b0;
      i_valid = 1'b0;
      i_din   = '0;
      set_cfg(3, 2'b11, 2'b00, 1'b0);
      #1;

      // Reset values
      step();
      step();
      reset_n = 1'b1;
      step();
      check_eq("rst_txd",   o_txd,      1'b1);
      check_eq("rst_busy",  o_busy,     1'b0);
      check_eq("rst_level", o_level,    '0);
      check_eq("rst_empty", fifo_empty, 1'b1);
      check_eq("rst_full",  fifo_full,  1'b0);
      check_eq("rst_ovf",   o_ovf,      1'b0);

      // 8N1, period 3: start bit one cycle after the push edge
      set_cfg(3, 2'b11, 2'b00, 1'b0);
      push_byte(8'h55);
      check_eq("lat_level", o_level, 1);
      step();
      check_eq("lat_txd",  o_txd,  1'b0);
      check_eq("lat_busy", o_busy, 1'b1);
      drain("8n1", 100);

      // 7E2 then 7O2, period 1
      set_cfg(1, 2'b10, 2'b10, 1'b1);
      push_byte(8'h41);
      drain("7e2", 100);
      set_cfg(1, 2'b10, 2'b01, 1'b1);
      push_byte(8'h41);
      drain("7o2", 100);

      // 5-bit mark parity, back-to-back frames
      set_cfg(2, 2'b00, 2'b11, 1'b0);
      push_byte(8'hFF);
      push_byte(8'h00);
      drain("mark", 200);

      // Fill to full and overflow; later frames use a faster period
      set_cfg(100, 2'b11, 2'b00, 1'b0);
      ovf_seen = 0;
      for (int k = 0; k < 10; k++) begin
         i_valid = 1'b1;
         i_din   = 8'(8'h30 + k);
         step();
         if (o_ovf) ovf_seen++;
         if (k == 8) begin
            check_eq("full_level", o_level,   8);
            check_eq("full_flag",  fifo_full, 1'b1);
         end
      end
      i_valid = 1'b0;
      check_eq("ovf_pulse", o_ovf, 1'b1);
      step();
      check_eq("ovf_clear", o_ovf, 1'b0);
      check_eq("ovf_count", ovf_seen, 1);
      set_cfg(3, 2'b11, 2'b00, 1'b0);
      drain("full", 20000);

      // Reset during DATA with 3 entries queued
      set_cfg(3, 2'b11, 2'b00, 1'b0);
      for (int k = 0; k < 4; k++) push_byte(8'(8'hC0 + k));
      repeat (6) step();
      reset_n = 1'b0;
      step();
      check_eq("midrst_txd",   o_txd,   1'b1);
      check_eq("midrst_level", o_level, 0);
      reset_n = 1'b1;
      repeat (60) step();
      check_eq("midrst_quiet", o_busy, 1'b0);
      push_byte(8'hA5);
      drain("a5", 100);

      // Random traffic with config churn and occasional reset
      for (int c = 0; c < 4000; c++) begin
         i_valid = ($urandom_range(0, 3) == 0);
         i_din   = 8'($urandom);
         if ($urandom_range(0, 40) == 0)
            set_cfg($urandom_range(0, 3), 2'($urandom), 2'($urandom), 1'($urandom));
         reset_n = ($urandom_range(0, 999) != 0);
         step();
      end
      reset_n = 1'b1;
      drain("rand", 5000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
